// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer: FSM state encoding,
// reset PC and the opcode that marks HLT.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetchState_t;

    localparam logic [15:0] RESET_PC_DEFAULT    = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE_DEFAULT = 4'hF;

endpackage

// File: rtl/add_16bit.sv
// Plain ripple-style adder with carry in/out; the fetch sequencer uses it
// for the sequential PC+2 increment.
module add_16bit #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the architectural PC and drives a multi-cycle instruction memory,
// presenting fetched instructions to the IF/ID boundary with stall, redirect and HLT handling.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(RESET_PC_DEFAULT),
    parameter logic [3:0]       HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] pc_plus2,
    output logic             instr_valid,
    output logic             halted,
    output logic [1:0]       dbgState
);

    fetchState_t      state, stateNext;
    logic [WIDTH-1:0] pc, pcNext;
    logic [WIDTH-1:0] pcInc;
    logic             pend, pendNext;
    logic [WIDTH-1:0] pendPc, pendPcNext;
    logic [WIDTH-1:0] skid, skidNext;
    logic [WIDTH-1:0] skidPc, skidPcNext;
    logic [WIDTH-1:0] instrNext, instrPcNext, pcPlus2Next;
    logic             validNext;
    logic             consumed, slotFree;
    logic             unusedCout;

    function automatic logic isHalt(input logic [WIDTH-1:0] word);
        return word[WIDTH-1 -: 4] == HALT_OPCODE;
    endfunction

    add_16bit #(.WIDTH(WIDTH)) pcAdder (
        .a    (pc),
        .b    (WIDTH'(2)),
        .cin  (1'b0),
        .sum  (pcInc),
        .cout (unusedCout)
    );

    // Memory handshake: imem_req stays high with imem_addr frozen (pc only moves
    // on the ack edge) until imem_ack is sampled; the request is never withdrawn
    // except by reset, which drops it asynchronously.
    assign imem_req  = rst_n && (state == FETCH);
    assign imem_addr = pc;
    assign halted    = (state == HALTED);
    assign dbgState  = state;

    assign consumed = instr_valid && !stall;
    assign slotFree = !instr_valid || !stall;

    always_comb begin
        stateNext   = state;
        pcNext      = pc;
        pendNext    = pend;
        pendPcNext  = pendPc;
        skidNext    = skid;
        skidPcNext  = skidPc;
        instrNext   = instr;
        instrPcNext = instr_pc;
        pcPlus2Next = pc_plus2;
        validNext   = instr_valid;

        case (state)
            FETCH: begin
                if (consumed) validNext = 1'b0;
                if (imem_ack) begin
                    if (redirect || pend) begin
                        // Data belongs to the squashed path; a live redirect is younger than pend.
                        pcNext   = redirect ? redirect_pc : pendPc;
                        pendNext = 1'b0;
                        if (redirect) validNext = 1'b0;
                    end else if (slotFree) begin
                        instrNext   = imem_data;
                        instrPcNext = pc;
                        pcPlus2Next = pcInc;
                        validNext   = 1'b1;
                        pcNext      = pcInc;
                        if (isHalt(imem_data)) stateNext = HALTED;
                    end else begin
                        skidNext   = imem_data;
                        skidPcNext = pc;
                        pcNext     = pcInc;
                        stateNext  = HOLD;
                    end
                end else if (redirect) begin
                    pendNext   = 1'b1;
                    pendPcNext = redirect_pc;
                    validNext  = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    validNext = 1'b0;
                    pcNext    = redirect_pc;
                    stateNext = FETCH;
                end else if (!stall) begin
                    // pc already advanced past the skid entry, so it is the entry's PC+2.
                    instrNext   = skid;
                    instrPcNext = skidPc;
                    pcPlus2Next = pc;
                    validNext   = 1'b1;
                    stateNext   = isHalt(skid) ? HALTED : FETCH;
                end
            end
            HALTED: begin
                if (redirect) begin
                    validNext = 1'b0;
                    pcNext    = redirect_pc;
                    stateNext = FETCH;
                end else if (consumed) begin
                    validNext = 1'b0;
                end
            end
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pend        <= 1'b0;
            pendPc      <= '0;
            skid        <= '0;
            skidPc      <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            pc_plus2    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= stateNext;
            pc          <= pcNext;
            pend        <= pendNext;
            pendPc      <= pendPcNext;
            skid        <= skidNext;
            skidPc      <= skidPcNext;
            instr       <= instrNext;
            instr_pc    <= instrPcNext;
            pc_plus2    <= pcPlus2Next;
            instr_valid <= validNext;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table for the main
// flow plus hand-written reset sequences.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPc;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemAck;
    logic [15:0] imemData;
    logic [15:0] instr;
    logic [15:0] instrPc;
    logic [15:0] pcPlus2;
    logic        instrValid;
    logic        halted;
    logic [1:0]  dbgState;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        ack;
        logic [15:0] data;
        logic        eReq;
        logic [15:0] eAddr;
        logic        eValid;
        logic [15:0] eInstr;
        logic [15:0] eIpc;
        logic [15:0] eP2;
        logic        eHalted;
    } vec_t;

    vec_t vecs[$];

    fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .imem_req    (imemReq),
        .imem_addr   (imemAddr),
        .imem_ack    (imemAck),
        .imem_data   (imemData),
        .instr       (instr),
        .instr_pc    (instrPc),
        .pc_plus2    (pcPlus2),
        .instr_valid (instrValid),
        .halted      (halted),
        .dbgState    (dbgState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic addVec(input logic st, input logic rd, input logic [15:0] rpc,
                          input logic ak, input logic [15:0] dat,
                          input logic eReq, input logic [15:0] eAddr, input logic eValid,
                          input logic [15:0] eInstr, input logic [15:0] eIpc,
                          input logic [15:0] eP2, input logic eHalted);
        vec_t v;
        v.stall = st; v.redirect = rd; v.rpc = rpc; v.ack = ak; v.data = dat;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eValid; v.eInstr = eInstr;
        v.eIpc = eIpc; v.eP2 = eP2; v.eHalted = eHalted;
        vecs.push_back(v);
    endtask

    task automatic driveIdle();
        stall = 1'b0; redirect = 1'b0; redirectPc = 16'h0000;
        imemAck = 1'b0; imemData = 16'h0000;
    endtask

    initial begin
        driveIdle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req",    {15'b0, imemReq},    16'h0000);
        check("reset_valid",  {15'b0, instrValid}, 16'h0000);
        check("reset_instr",  instr,               16'h0000);
        check("reset_ipc",    instrPc,             16'h0000);
        check("reset_p2",     pcPlus2,             16'h0000);
        check("reset_halted", {15'b0, halted},     16'h0000);

        // Per-cycle rows: inputs held for the cycle, outputs expected during it.
        //     stl rd  rpc      ack data      req addr     vld instr     ipc       p2        hlt
        addVec(0,  0,  16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(0,  0,  16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(0,  0,  16'h0000, 1, 16'h1234, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(0,  0,  16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 16'h1234, 16'h0000, 16'h0002, 0);
        addVec(0,  0,  16'h0000, 0, 16'h0000, 1, 16'h0002, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(0,  0,  16'h0000, 1, 16'h5678, 1, 16'h0002, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1,  0,  16'h0000, 0, 16'h0000, 1, 16'h0004, 1, 16'h5678, 16'h0002, 16'h0004, 0);
        addVec(1,  0,  16'h0000, 1, 16'h1111, 1, 16'h0004, 1, 16'h5678, 16'h0002, 16'h0004, 0);
        addVec(1,  0,  16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h5678, 16'h0002, 16'h0004, 0);
        addVec(0,  0,  16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h5678, 16'h0002, 16'h0004, 0);
        addVec(0,  0,  16'h0000, 1, 16'h2222, 1, 16'h0006, 1, 16'h1111, 16'h0004, 16'h0006, 0);
        addVec(0,  1,  16'h0040, 0, 16'h0000, 1, 16'h0008, 1, 16'h2222, 16'h0006, 16'h0008, 0);
        addVec(0,  0,  16'h0000, 1, 16'h3333, 1, 16'h0008, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(0,  1,  16'h000A, 1, 16'h4444, 1, 16'h0040, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(0,  0,  16'h0000, 1, 16'hF000, 1, 16'h000A, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1,  0,  16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'hF000, 16'h000A, 16'h000C, 1);
        addVec(0,  0,  16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'hF000, 16'h000A, 16'h000C, 1);
        addVec(0,  1,  16'h0100, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 1);
        addVec(0,  0,  16'h0000, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(0,  1,  16'hFFFE, 1, 16'h5555, 1, 16'h0100, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(0,  0,  16'h0000, 1, 16'h6666, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1,  0,  16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 16'h6666, 16'hFFFE, 16'h0000, 0);
        addVec(1,  0,  16'h0000, 1, 16'h7777, 1, 16'h0000, 1, 16'h6666, 16'hFFFE, 16'h0000, 0);
        addVec(1,  1,  16'h0200, 0, 16'h0000, 0, 16'h0000, 1, 16'h6666, 16'hFFFE, 16'h0000, 0);
        addVec(0,  0,  16'h0000, 1, 16'h8888, 1, 16'h0200, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        addVec(1,  0,  16'h0000, 0, 16'h0000, 1, 16'h0202, 1, 16'h8888, 16'h0200, 16'h0202, 0);

        rst_n = 1'b1;
        foreach (vecs[i]) begin
            if (i > 0) @(negedge clk);
            stall      = vecs[i].stall;
            redirect   = vecs[i].redirect;
            redirectPc = vecs[i].rpc;
            imemAck    = vecs[i].ack;
            imemData   = vecs[i].data;
            #1;
            check($sformatf("v%0d_req", i), {15'b0, imemReq}, {15'b0, vecs[i].eReq});
            if (vecs[i].eReq) check($sformatf("v%0d_addr", i), imemAddr, vecs[i].eAddr);
            check($sformatf("v%0d_valid", i), {15'b0, instrValid}, {15'b0, vecs[i].eValid});
            if (vecs[i].eValid) begin
                check($sformatf("v%0d_instr", i), instr, vecs[i].eInstr);
                check($sformatf("v%0d_ipc", i), instrPc, vecs[i].eIpc);
                check($sformatf("v%0d_p2", i), pcPlus2, vecs[i].eP2);
            end
            check($sformatf("v%0d_halted", i), {15'b0, halted}, {15'b0, vecs[i].eHalted});
        end

        // Reset asserted while a request is outstanding and the output slot is full.
        @(negedge clk);
        driveIdle();
        stall = 1'b1;
        #1;
        check("pre_rst_req",   {15'b0, imemReq},    16'h0001);
        check("pre_rst_valid", {15'b0, instrValid}, 16'h0001);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req",   {15'b0, imemReq},    16'h0000);
        check("mid_rst_valid", {15'b0, instrValid}, 16'h0000);
        check("mid_rst_instr", instr,               16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        imemAck = 1'b1;
        imemData = 16'h9999;
        #1;
        check("post_rst_req",  {15'b0, imemReq}, 16'h0001);
        check("post_rst_addr", imemAddr,         16'h0000);
        @(negedge clk);
        driveIdle();
        #1;
        check("post_rst_valid", {15'b0, instrValid}, 16'h0001);
        check("post_rst_instr", instr,               16'h9999);
        check("post_rst_ipc",   instrPc,             16'h0000);
        check("post_rst_p2",    pcPlus2,             16'h0002);
        check("post_rst_addr2", imemAddr,            16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the architectural PC and sequences instruction fetch from a multi-cycle instruction memory (req/ack handshake) into the IF/ID boundary.
- Arbitrates between sequential PC+2, branch redirects from later stages, hazard-unit stalls and HLT detection.
- Replaces ad-hoc stall/halt muxing around the PC register with one registered controller that feeds the IF/ID pipeline register.

Parameters:
- WIDTH, 16, PC and instruction width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, value of instr[15:12] that marks HLT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hazard unit: IF/ID must not accept a new instruction this cycle.
- redirect  in  1  taken branch/jump resolved; flush fetch.
- redirect_pc  in  WIDTH  target PC, valid with redirect.
- imem_req  out  1  fetch request.
- imem_addr  out  WIDTH  fetch address, stable while imem_req is high.
- imem_ack  in  1  memory returns imem_data this cycle.
- imem_data  in  WIDTH  fetched instruction.
- instr  out  WIDTH  instruction to IF/ID.
- instr_pc  out  WIDTH  PC of instr.
- pc_plus2  out  WIDTH  instr_pc + 2, for link/branch base.
- instr_valid  out  1  instr/instr_pc/pc_plus2 valid.
- halted  out  1  HLT fetched; fetch stopped.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, redirect pending flag clear.
  - instr_valid=0, instr=0, instr_pc=0, pc_plus2=0, halted=0, skid buffer empty.
  - imem_req=0 while in reset.
- Latency: first cycle after rst_n rises, imem_req=1 and imem_addr=RESET_PC.
  - instr_valid rises the edge after imem_ack is sampled (1-cycle registered output).
- Consumption: IF/ID takes the output when instr_valid && !stall.
- Handshake: once imem_req is raised, it is held with an unchanged imem_addr until imem_ack is sampled. A request is never aborted.
- States: FETCH, HOLD, HALTED.
- FETCH: imem_req=1, imem_addr=pc.
  - redirect with no imem_ack: capture pend_pc=redirect_pc, set pend, clear instr_valid. Keep the request outstanding.
  - imem_ack while redirect or pend is set: discard imem_data.
    - pc <= redirect ? redirect_pc : pend_pc; a live redirect wins over pend. Clear pend.
    - Stay in FETCH.
  - imem_ack, no redirect, output slot free or being consumed: load instr/instr_pc=pc/pc_plus2=pc+2, set instr_valid=1, pc <= pc+2.
    - Next state is HALTED if imem_data[15:12]==HALT_OPCODE, else FETCH.
  - imem_ack, no redirect, slot full and stall=1: write imem_data into the 1-entry skid buffer, pc <= pc+2, go to HOLD.
  - Slot consumed, no ack: instr_valid <= 0.
- HOLD: imem_req=0.
  - stall=0: move skid to the output regs, set instr_valid=1.
    - Next state is HALTED if the skid entry is HLT, else FETCH.
  - redirect: flush skid and output (instr_valid=0), pc <= redirect_pc, go to FETCH.
- HALTED: halted=1, imem_req=0. The HLT instruction remains deliverable on the output until consumed.
  - redirect (branch older than HLT): clear halted and instr_valid, pc <= redirect_pc, go to FETCH.
  - stall does not leave HALTED.
- Priority: redirect > stall > sequential. A redirect always clears instr_valid on the next edge.
- Arithmetic: PC+2 is modulo 2^WIDTH. 16'hFFFE+2 = 16'h0000, no flag. Bit 0 of PC is never altered; redirect_pc is used as given.
- Reset mid-request: all state is cleared immediately and imem_req drops asynchronously. Memory must tolerate a dropped request.

Decomposition:
- Package fetch_pkg holds the state enum (FETCH/HOLD/HALTED, 2-bit), RESET_PC default and HALT_OPCODE.
- One sub-module: the existing add_16bit, instantiated for pc+2 (Cin=0, Cout unused). A second instance is used or pc_plus2 is registered from the same sum.
- The FSM, skid buffer and output registers stay in fetch_sequencer.

Test Plan:
- Reset release, imem_ack 2 cycles after each req, data 16'h1234 then 16'h5678 -> imem_addr 0x0000 then 0x0002. Outputs are instr_pc 0x0000 with pc_plus2 0x0002, then instr_pc 0x0002; instr_valid pulses.
- stall=1 held for 3 cycles while a fetch at 0x0004 acks -> HOLD, imem_req=0, output unchanged. On stall=0, instr_pc=0x0004 is presented and the next req goes to 0x0006.
- redirect=1, redirect_pc=0x0040 one cycle before ack of outstanding 0x0008 -> ack data discarded, instr_valid=0, next imem_addr=0x0040.
- Fetch 16'hF000 at 0x000A -> instr_valid with HLT, halted=1, no further imem_req. Then redirect to 0x0100 -> halted=0 and req at 0x0100.
- redirect_pc=0xFFFE, ack -> instr_pc=0xFFFE, pc_plus2=0x0000, next imem_addr=0x0000.
- rst_n low while imem_req high mid-wait -> imem_req and instr_valid are 0 immediately. After release, req at RESET_PC.
